bsg_link_osdr_tx: RTL
=====================

BSG_LINK_OSDR_TX -- requirements
Module: bsg_link_osdr_tx

Interface
REQ-001 SHALL have parameter width_p, default "inv" (must be overridden); off-chip data width in bits.
REQ-002 SHALL have parameter lg_fifo_depth_p, default 3; log2 of the remote receive FIFO depth, which sets the initial credit count.
REQ-003 SHALL have parameter lg_credit_to_token_decimation_p, default 0; each token pulse returns 2^this credits.
REQ-004 SHALL have parameter sync_cycles_p, default 16; number of idle cycles after reset before the link goes active.
REQ-005 SHALL have port clk_i, input, 1 bit; the single core/IO clock; all state is on its rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit; synchronous, active-high reset.
REQ-007 SHALL have port v_i, input, 1 bit; core data valid.
REQ-008 SHALL have port data_i, input, width_p bits; core data.
REQ-009 SHALL have port ready_and_o, output, 1 bit; the block accepts data when v_i and ready_and_o are both high.
REQ-010 SHALL have port token_i, input, 1 bit; single-cycle credit-return pulse, already synchronized to clk_i.
REQ-011 SHALL have port io_clk_o, output, 1 bit; forwarded clock, the inverted clk_i driven through the clock sub-module.
REQ-012 SHALL have port io_v_r_o, output, 1 bit; registered valid.
REQ-013 SHALL have port io_data_r_o, output, width_p bits; registered data.
REQ-014 SHALL have port active_o, output, 1 bit; high while the state machine is in ACTIVE.

Function
REQ-015 SHALL implement a state machine with states RESET, SYNC and ACTIVE.
REQ-016 SHALL go to SYNC on the first cycle after reset_i deasserts; SYNC SHALL last exactly sync_cycles_p cycles and then go to ACTIVE.
REQ-017 SHALL hold io_v_r_o=0 and ready_and_o=0 in RESET and SYNC; io_clk_o SHALL toggle in every state.
REQ-018 SHALL keep a credit counter of width lg_fifo_depth_p+1 that resets to 2^lg_fifo_depth_p.
REQ-019 SHALL drive ready_and_o = (state==ACTIVE) && (credits!=0), combinationally from registers only.
REQ-020 SHALL on acceptance register data_i into io_data_r_o and set io_v_r_o=1 on the next edge, so output latency is 1 cycle.
REQ-021 SHALL on a non-accept cycle set io_v_r_o=0.
REQ-022 SHALL update credits by -1 on acceptance and by +2^lg_credit_to_token_decimation_p on token_i; both in one cycle SHALL apply the net sum.
REQ-023 SHALL treat a token_i that would push credits above 2^lg_fifo_depth_p as a protocol error; the counter SHALL saturate at the maximum and a simulation error SHALL be printed.
REQ-024 SHALL ignore token_i outside ACTIVE and leave credits at the reset value.
REQ-025 SHALL accept back-to-back transfers with no bubbles while credits are nonzero.
REQ-026 SHALL never let an acceptance and credits==0 occur in the same cycle (no underflow).

Reset
REQ-027 SHALL on reset_i=1, including mid-transfer, within one edge set state=RESET, credits=2^lg_fifo_depth_p, io_v_r_o=0, io_data_r_o=0, ready_and_o=0, active_o=0 and the SYNC counter to 0.
REQ-028 SHALL keep io_clk_o running during reset.

Configuration
REQ-029 SHALL use macro BSG_LINK_OSDR_TX_IDLE_ZERO_EN: when defined, io_data_r_o SHALL be driven to 0 on every cycle where io_v_r_o will be 0.
REQ-030 SHALL, when BSG_LINK_OSDR_TX_IDLE_ZERO_EN is undefined, hold io_data_r_o at its last value on idle cycles to minimize toggling.

Structure
REQ-031 SHALL place the state enum (RESET/SYNC/ACTIVE) in the shared package bsg_link_pkg.
REQ-032 SHALL instantiate sub-module bsg_link_osdr_clk_buf, a hardened inverting clock buffer marked dont-touch, to produce io_clk_o from clk_i.

Verification
REQ-033 SHALL cover: reset release with sync_cycles_p=16 -> active_o=0 for 16 cycles, then 1; ready_and_o=0 throughout SYNC.
REQ-034 SHALL cover: lg_fifo_depth_p=3, v_i held high, no tokens -> exactly 8 transfers, then ready_and_o=0.
REQ-035 SHALL cover: data_i=0xA5 accepted at cycle N -> io_v_r_o=1 and io_data_r_o=0xA5 at cycle N+1.
REQ-036 SHALL cover: credits=0, then token_i together with v_i, with decimation 2 -> credits 0->4, the next cycle accepts, and credits reach 3.
REQ-037 SHALL cover: reset_i asserted mid-stream with credits=2 -> next cycle io_v_r_o=0, credits=8, state=RESET.
REQ-038 SHALL cover: idle cycle after data 0xFF -> io_data_r_o=0 with the macro defined, 0xFF without it.

Source files
------------

// File: rtl/bsg_link_pkg.sv
// Shared definitions for the bsg_link blocks: link bring-up state encoding.
// No logic; imported by the link transmitter and its helpers.
package bsg_link_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } link_state_e;

endpackage

// File: rtl/bsg_link_osdr_clk_buf.sv
// Inverting clock buffer forwarding the core clock off-chip; zero cycles, combinational.
// No flow control; kept as its own cell so physical design can treat it as a hardened, untouched buffer.
module bsg_link_osdr_clk_buf (
    input  logic clk_i,
    output logic clk_o
);

    (* dont_touch = "true" *) logic clk_inv;

    assign clk_inv = ~clk_i;
    assign clk_o   = clk_inv;

endmodule

// File: rtl/bsg_link_osdr_tx.sv
// Credit-gated single-data-rate link transmitter; define BSG_LINK_OSDR_TX_IDLE_ZERO_EN to zero io_data_r_o on idle cycles.
// Latency 1 cycle data_i -> io_data_r_o; ready_and_o is low outside ACTIVE or when the credit counter is empty.
module bsg_link_osdr_tx
    import bsg_link_pkg::*;
#(
    parameter width_p                         = "inv",
    parameter lg_fifo_depth_p                 = 3,
    parameter lg_credit_to_token_decimation_p = 0,
    parameter sync_cycles_p                   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_and_o,
    input  logic               token_i,
    output logic               io_clk_o,
    output logic               io_v_r_o,
    output logic [width_p-1:0] io_data_r_o,
    output logic               active_o
);

    localparam int cred_w = lg_fifo_depth_p + 1;
    localparam int sum_w  = lg_fifo_depth_p + lg_credit_to_token_decimation_p + 2;
    localparam int sync_w = (sync_cycles_p > 1) ? $clog2(sync_cycles_p) : 1;

    localparam logic [cred_w-1:0] cred_max  = cred_w'(2 ** lg_fifo_depth_p);
    localparam logic [sum_w-1:0]  tok_amt   = sum_w'(2 ** lg_credit_to_token_decimation_p);
    localparam logic [sync_w-1:0] sync_last = sync_w'(sync_cycles_p - 1);

    link_state_e       state_r, state_n;
    logic [sync_w-1:0] sync_cnt_r, sync_cnt_n;
    logic [cred_w-1:0] credits_r, credits_n;
    logic [sum_w-1:0]  credit_sum;
    logic              accept;
    logic              token_vld;
    logic              overflow;

    bsg_link_osdr_clk_buf clk_buf (
        .clk_i (clk_i),
        .clk_o (io_clk_o)
    );

    assign active_o    = (state_r == ACTIVE);
    assign ready_and_o = active_o && (credits_r != '0);
    assign accept      = v_i && ready_and_o;
    assign token_vld   = token_i && active_o;

    always_comb begin
        state_n    = state_r;
        sync_cnt_n = sync_cnt_r;
        case (state_r)
            RESET: begin
                state_n    = SYNC;
                sync_cnt_n = '0;
            end
            SYNC: begin
                if (sync_cnt_r == sync_last) begin
                    state_n = ACTIVE;
                end else begin
                    sync_cnt_n = sync_cnt_r + sync_w'(1);
                end
            end
            ACTIVE: state_n = ACTIVE;
            default: state_n = RESET;
        endcase
    end

    // Net credit change is computed wide so a token on top of a full counter is visible as overflow.
    always_comb begin
        credit_sum = sum_w'(credits_r) + (token_vld ? tok_amt : '0) - sum_w'(accept);
        overflow   = (credit_sum > sum_w'(cred_max));
        credits_n  = overflow ? cred_max : cred_w'(credit_sum);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= RESET;
            sync_cnt_r  <= '0;
            credits_r   <= cred_max;
            io_v_r_o    <= 1'b0;
            io_data_r_o <= '0;
        end else begin
            state_r    <= state_n;
            sync_cnt_r <= sync_cnt_n;
            credits_r  <= credits_n;
            io_v_r_o   <= accept;
            if (accept) begin
                io_data_r_o <= data_i;
            end
`ifdef BSG_LINK_OSDR_TX_IDLE_ZERO_EN
            else begin
                io_data_r_o <= '0;
            end
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && overflow) begin
            $error("bsg_link_osdr_tx: token return overflows credit counter (credits=%0d)", credits_r);
        end
    end
`endif

endmodule
